// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states,
// bus owner encoding and the access-mode codes also used by data memory.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Access size in bits [1:0], bit 2 set selects zero-extension on loads.
    localparam logic [2:0] AM_BYTE   = 3'b000;
    localparam logic [2:0] AM_HALF   = 3'b001;
    localparam logic [2:0] AM_WORD   = 3'b010;
    localparam logic [2:0] AM_BYTE_U = 3'b100;
    localparam logic [2:0] AM_HALF_U = 3'b101;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and data requests.
// ARB_RR_EN defined: round-robin, the side not served last wins a collision.
// ARB_RR_EN undefined: fixed priority, data side always wins a collision.
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic   clk,
    input  logic   rst,
    input  logic   take,
`endif
    input  logic   req_if,
    input  logic   req_mem,
    output logic   gnt_valid,
    output owner_e gnt_owner
);

`ifdef ARB_RR_EN
    owner_e last_q;
    owner_e last_d;

    // Remember who was granted most recently; only a taken grant counts.
    always_comb begin
        last_d = last_q;
        if (take && gnt_valid) begin
            last_d = gnt_owner;
        end
    end

    // Last-served register; reset favours the data side on the first collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end

    // Round-robin pick: a lone requester wins, a collision goes to the other side.
    always_comb begin
        gnt_valid = req_if | req_mem;
        gnt_owner = req_mem ? OWN_MEM : OWN_IF;
        if (req_if && req_mem) begin
            gnt_owner = (last_q == OWN_MEM) ? OWN_IF : OWN_MEM;
        end
    end
`else
    // Fixed pick: the older instruction (data side) wins a collision.
    always_comb begin
        gnt_valid = req_if | req_mem;
        gnt_owner = req_mem ? OWN_MEM : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory bus shared by the fetch and data stages.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// Arbitration mode selected by ARB_RR_EN (see arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             if_kill,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_done,
    output logic             if_stall,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_wdata,
    input  logic [2:0]       mem_addrmode,
    output logic [WIDTH-1:0] mem_rdata,
    output logic             mem_done,
    output logic             mem_stall,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [2:0]       bus_addrmode,
    input  logic             bus_ready,
    input  logic             bus_rvalid,
    input  logic [WIDTH-1:0] bus_rdata
);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             kill_q, kill_d;
    logic             we_q, we_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             gnt_valid;
    owner_e           gnt_owner;

    // A flushed fetch is not eligible for a grant in the same cycle.
    arb_pick u_pick (
`ifdef ARB_RR_EN
        .clk       (clk),
        .rst       (rst),
        .take      (state_q == IDLE),
`endif
        .req_if    (if_req & ~if_kill),
        .req_mem   (mem_req),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    // Next-state and command latching; bus_rvalid only matters in WAIT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        kill_d  = kill_q;
        we_d    = we_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = ISSUE;
                    owner_d = gnt_owner;
                    kill_d  = 1'b0;
                    if (gnt_owner == OWN_MEM) begin
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_we;
                        mode_d  = mem_addrmode;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                        mode_d  = AM_WORD;
                    end
                end
            end
            ISSUE: begin
                if (bus_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush lets the bus transaction finish but swallows its done pulse.
        if ((state_q != IDLE) && (owner_q == OWN_IF) && if_kill) begin
            kill_d = 1'b1;
        end
    end

    // State and command registers; reset abandons any bus response in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            kill_q  <= 1'b0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus_req      = (state_q == ISSUE);
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign bus_addrmode = mode_q;

    // A flush arriving in the DONE cycle itself also suppresses the pulse.
    assign if_done  = (state_q == DONE) && (owner_q == OWN_IF) && !kill_q && !if_kill;
    assign mem_done = (state_q == DONE) && (owner_q == OWN_MEM);

    assign if_rdata  = rdata_q;
    assign mem_rdata = rdata_q;

    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters and bus, checked every cycle
// against a transaction-level model. Honours ARB_RR_EN in the model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_addrmode;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_addrmode;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_kill      (if_kill),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .if_stall     (if_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addrmode (mem_addrmode),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .mem_stall    (mem_stall),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addrmode (bus_addrmode),
        .bus_ready    (bus_ready),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Transaction-level model: at most one transaction outstanding.
    logic        t_active, t_accepted, t_answered, t_killed, t_mem, t_we;
    logic [31:0] t_addr, t_wdata, t_data, last_data;
    logic [2:0]  t_mode;
`ifdef ARB_RR_EN
    logic        last_mem;
`endif

    logic        obs_if_done, obs_mem_done, obs_if_stall, obs_bus_req, obs_bus_we;
    logic [31:0] obs_if_rdata, obs_mem_rdata, obs_bus_addr, obs_bus_wdata;
    logic [2:0]  obs_bus_mode;
    logic        pe_if_done, pe_mem_done;

    logic [2:0]  modes [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        t_active   = 1'b0;
        t_accepted = 1'b0;
        t_answered = 1'b0;
        t_killed   = 1'b0;
        last_data  = 32'h0;
`ifdef ARB_RR_EN
        last_mem   = 1'b0;
`endif
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compare();
        logic        e_if, e_mem;
        logic [31:0] e_rd;
        e_if  = t_active && t_answered && !t_mem && !t_killed && !if_kill;
        e_mem = t_active && t_answered && t_mem;
        e_rd  = (t_active && t_answered) ? t_data : last_data;
        chk("bus_req",   32'(bus_req),   32'(t_active && !t_accepted));
        chk("if_done",   32'(if_done),   32'(e_if));
        chk("mem_done",  32'(mem_done),  32'(e_mem));
        chk("if_stall",  32'(if_stall),  32'(if_req && !e_if));
        chk("mem_stall", 32'(mem_stall), 32'(mem_req && !e_mem));
        chk("if_rdata",  if_rdata,  e_rd);
        chk("mem_rdata", mem_rdata, e_rd);
        if (t_active && !t_accepted) begin
            chk("bus_addr", bus_addr, t_addr);
            chk("bus_we", 32'(bus_we), 32'(t_we));
            if (t_mem) begin
                chk("bus_wdata", bus_wdata, t_wdata);
                chk("bus_addrmode", 32'(bus_addrmode), 32'(t_mode));
            end
        end
        obs_if_done   = if_done;
        obs_mem_done  = mem_done;
        obs_if_stall  = if_stall;
        obs_bus_req   = bus_req;
        obs_bus_we    = bus_we;
        obs_if_rdata  = if_rdata;
        obs_mem_rdata = mem_rdata;
        obs_bus_addr  = bus_addr;
        obs_bus_wdata = bus_wdata;
        obs_bus_mode  = bus_addrmode;
        pe_if_done    = e_if;
        pe_mem_done   = e_mem;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic advance();
        logic ei, em, pick_mem;
        if (!rst) begin
            m_reset();
        end else if (!t_active) begin
            ei = if_req && !if_kill;
            em = mem_req;
            if (ei || em) begin
`ifdef ARB_RR_EN
                pick_mem = em && (!ei || !last_mem);
                last_mem = pick_mem;
`else
                pick_mem = em;
`endif
                t_active   = 1'b1;
                t_accepted = 1'b0;
                t_answered = 1'b0;
                t_killed   = 1'b0;
                t_mem      = pick_mem;
                t_addr     = pick_mem ? mem_addr : if_addr;
                t_we       = pick_mem ? mem_we : 1'b0;
                t_wdata    = mem_wdata;
                t_mode     = mem_addrmode;
            end
        end else if (!t_accepted) begin
            if (!t_mem && if_kill) t_killed = 1'b1;
            if (bus_ready) t_accepted = 1'b1;
        end else if (!t_answered) begin
            if (!t_mem && if_kill) t_killed = 1'b1;
            if (bus_rvalid) begin
                t_answered = 1'b1;
                t_data     = bus_rdata;
            end
        end else begin
            last_data = t_data;
            t_active  = 1'b0;
        end
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic run_cycle();
        #4;
        compare();
        advance();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_pulse();
        #1;
        rst = 1'b0;
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_mem_done", 32'(mem_done), 32'h0);
        chk("rst_rdata", if_rdata, 32'h0);
        m_reset();
        #2;
        compare();
        advance();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int at;
    int at2;
    logic [31:0] d1, d2;
    int pulses;

    initial begin
        modes = '{AM_BYTE, AM_HALF, AM_WORD, AM_BYTE_U, AM_HALF_U};
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_addrmode = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        m_reset();
        pe_if_done = 1'b0; pe_mem_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_bus_req", 32'(bus_req), 32'h0);
        chk("reset_bus_we", 32'(bus_we), 32'h0);
        chk("reset_if_done", 32'(if_done), 32'h0);
        chk("reset_mem_done", 32'(mem_done), 32'h0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk("reset_bus_wdata", bus_wdata, 32'h0);
        chk("reset_rdata", if_rdata, 32'h0);
        rst = 1'b1;

        // Lone fetch: done in cycle 3 with the bus response.
        if_req = 1'b1; if_addr = 32'h100; bus_ready = 1'b1;
        at = -1; d1 = '0;
        for (int c = 0; c < 10; c++) begin
            bus_rvalid = (c == 2);
            bus_rdata  = (c == 2) ? 32'h00500093 : 32'hFFFFFFFF;
            run_cycle();
            if (c == 0) chk("t1_stall_c0", 32'(obs_if_stall), 32'h1);
            if (obs_if_done) begin at = c; d1 = obs_if_rdata; break; end
        end
        chk("t1_done_cycle", 32'(at), 32'd3);
        chk("t1_rdata", d1, 32'h00500093);
        if_req = 1'b0; bus_rvalid = 1'b0;
        run_cycle();

        // Collision: data load first (cycle 3), fetch next (cycle 7).
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_addrmode = AM_WORD;
        bus_ready = 1'b1; bus_rvalid = 1'b1;
        at = -1; at2 = -1; d1 = '0; d2 = '0;
        for (int c = 0; c < 16; c++) begin
            bus_rdata = 32'hA0000000 + 32'(c);
            run_cycle();
            if (obs_mem_done) begin at = c; d1 = obs_mem_rdata; mem_req = 1'b0; end
            if (obs_if_done) begin at2 = c; d2 = obs_if_rdata; break; end
        end
        chk("t2_mem_done_cycle", 32'(at), 32'd3);
        chk("t2_mem_rdata", d1, 32'hA0000002);
        chk("t2_if_done_cycle", 32'(at2), 32'd7);
        chk("t2_if_rdata", d2, 32'hA0000006);
        if_req = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b0;
        run_cycle();

        // Byte store with three cycles of bus back-pressure.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2004; mem_wdata = 32'hDEADBEEF;
        mem_addrmode = AM_BYTE; bus_rvalid = 1'b1;
        at = -1;
        for (int c = 0; c < 16; c++) begin
            bus_ready = (c >= 4);
            bus_rdata = 32'h0BAD0000 + 32'(c);
            run_cycle();
            if (c == 2) begin
                chk("t3_bus_req", 32'(obs_bus_req), 32'h1);
                chk("t3_bus_addr", obs_bus_addr, 32'h2004);
                chk("t3_bus_wdata", obs_bus_wdata, 32'hDEADBEEF);
                chk("t3_bus_we", 32'(obs_bus_we), 32'h1);
                chk("t3_bus_mode", 32'(obs_bus_mode), 32'(AM_BYTE));
            end
            if (obs_mem_done) begin at = c; break; end
        end
        chk("t3_mem_done_cycle", 32'(at), 32'd6);
        mem_req = 1'b0; mem_we = 1'b0; bus_rvalid = 1'b0; bus_ready = 1'b1;
        run_cycle();

        // Flush during WAIT: response consumed silently, redirected fetch served.
        if_req = 1'b1; if_addr = 32'h108;
        at = -1; d1 = '0; pulses = 0;
        for (int c = 0; c < 16; c++) begin
            if_kill    = (c == 2);
            if (c == 3) if_addr = 32'h200;
            bus_rvalid = (c == 3) || (c == 7);
            bus_rdata  = 32'hC0000000 + 32'(c);
            run_cycle();
            if (c == 6) chk("t4_bus_addr", obs_bus_addr, 32'h200);
            if (obs_if_done) begin at = c; d1 = obs_if_rdata; break; end
        end
        chk("t4_done_cycle", 32'(at), 32'd8);
        chk("t4_rdata", d1, 32'hC0000007);
        if_req = 1'b0; if_kill = 1'b0; bus_rvalid = 1'b0;
        run_cycle();

        // Reset while waiting for a response, then a fresh fetch.
        if_req = 1'b1; if_addr = 32'h10C; bus_rvalid = 1'b0;
        run_cycle();
        run_cycle();
        async_reset_pulse();
        if_addr = 32'h300;
        at = -1; d1 = '0;
        for (int c = 0; c < 10; c++) begin
            bus_rvalid = (c == 2);
            bus_rdata  = 32'h00700113;
            run_cycle();
            if (obs_if_done) begin at = c; d1 = obs_if_rdata; break; end
        end
        chk("t5_done_cycle", 32'(at), 32'd3);
        chk("t5_rdata", d1, 32'h00700113);
        if_req = 1'b0; bus_rvalid = 1'b0;
        run_cycle();

        // Spurious response while idle is ignored.
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'h12345678;
            run_cycle();
            if (obs_if_done || obs_mem_done) pulses++;
        end
        chk("t6_no_done", 32'(pulses), 32'h0);
        chk("t6_rdata_held", obs_if_rdata, 32'h00700113);
        bus_rvalid = 1'b0;
        run_cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (!if_req || pe_if_done) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom() & 32'hFFFFFFFC;
            end
            if_kill = ($urandom_range(0, 15) == 0);
            if (if_kill) if_addr = $urandom() & 32'hFFFFFFFC;
            if (!mem_req || pe_mem_done) begin
                mem_req      = ($urandom_range(0, 2) != 0);
                mem_we       = 1'($urandom_range(0, 1));
                mem_addr     = $urandom();
                mem_wdata    = $urandom();
                mem_addrmode = modes[$urandom_range(0, 4)];
            end
            bus_ready  = ($urandom_range(0, 2) != 0);
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom();
            if (i == 2000) begin
                async_reset_pulse();
            end else begin
                run_cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
